// File: rtl/mcpu_loader_pkg.sv
// mcpu_loader_pkg: MCPU sizes and the loader FSM states, shared with the MCPU core.
// Defining LOADER_CHECKSUM_EN adds the S_CSUM state.
package mcpu_loader_pkg;

    localparam int WORD_SIZE   = 16;
    localparam int OPCODE_SIZE = 4;
    localparam int RAM_SIZE    = 256;
    localparam int ADDR_SIZE   = 8;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_COLLECT, S_WRITE, S_DONE, S_ERR, S_CSUM} state_t;
`else
    typedef enum logic [1:0] {S_COLLECT, S_WRITE, S_DONE, S_ERR} state_t;
`endif

endpackage

// File: rtl/mcpu_loader_asm.sv
// mcpu_loader_asm: nibble shift register and 2-bit field index.
// LOADER_CHECKSUM_EN adds an XOR accumulator of the words written to RAM.
module mcpu_loader_asm #(
    parameter int WORD_SIZE   = mcpu_loader_pkg::WORD_SIZE,
    parameter int OPCODE_SIZE = mcpu_loader_pkg::OPCODE_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   shift_en,
    input  logic [OPCODE_SIZE-1:0] nibble,
`ifdef LOADER_CHECKSUM_EN
    input  logic                   acc_en,
    output logic [WORD_SIZE-1:0]   acc,
`endif
    output logic [WORD_SIZE-1:0]   word,
    output logic [1:0]             idx
);

    logic [WORD_SIZE-1:0] word_q, word_d;
    logic [1:0]           idx_q, idx_d;

    // The index wraps to 0 on the fourth nibble, so each word starts clean.
    always_comb begin
        word_d = shift_en ? {word_q[WORD_SIZE-OPCODE_SIZE-1:0], nibble} : word_q;
        idx_d  = shift_en ? idx_q + 2'd1 : idx_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [WORD_SIZE-1:0] acc_q;

    always_ff @(posedge clk) begin
        if (reset)
            acc_q <= '0;
        else if (acc_en)
            acc_q <= acc_q ^ word_q;
    end

    assign acc = acc_q;
`endif

    assign word = word_q;
    assign idx  = idx_q;

endmodule

// File: rtl/mcpu_loader.sv
// mcpu_loader: streams a nibble image into MCPU RAM and holds the CPU in reset until it is loaded.
// Defining LOADER_CHECKSUM_EN requires a trailing XOR checksum word before releasing the CPU.
module mcpu_loader #(
    parameter int WORD_SIZE   = mcpu_loader_pkg::WORD_SIZE,
    parameter int OPCODE_SIZE = mcpu_loader_pkg::OPCODE_SIZE,
    parameter int RAM_SIZE    = mcpu_loader_pkg::RAM_SIZE,
    parameter int ADDR_SIZE   = mcpu_loader_pkg::ADDR_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OPCODE_SIZE-1:0] in_nibble,
    input  logic                   in_last,
    output logic                   ram_we,
    output logic [ADDR_SIZE-1:0]   ram_addr,
    output logic [WORD_SIZE-1:0]   ram_wdata,
    output logic                   cpu_reset,
    output logic                   done,
    output logic                   error,
    output logic [ADDR_SIZE:0]     word_count
);

    import mcpu_loader_pkg::*;

    state_t               state_q;
    logic [ADDR_SIZE-1:0] ptr_q;
    logic [ADDR_SIZE:0]   cnt_q;
    logic                 last_q;
    logic                 in_ready_q, ram_we_q, cpu_reset_q, done_q, error_q;
    logic [WORD_SIZE-1:0] word;
    logic [1:0]           idx;
    logic                 xfer;

    assign xfer = in_valid & in_ready_q;

`ifdef LOADER_CHECKSUM_EN
    logic [WORD_SIZE-1:0] acc;
    logic [WORD_SIZE-1:0] csum_word;

    assign csum_word = {word[WORD_SIZE-OPCODE_SIZE-1:0], in_nibble};
`endif

    mcpu_loader_asm #(
        .WORD_SIZE  (WORD_SIZE),
        .OPCODE_SIZE(OPCODE_SIZE)
    ) u_asm (
        .clk     (clk),
        .reset   (reset),
        .shift_en(xfer),
        .nibble  (in_nibble),
`ifdef LOADER_CHECKSUM_EN
        .acc_en  (ram_we_q),
        .acc     (acc),
`endif
        .word    (word),
        .idx     (idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_COLLECT;
            ptr_q       <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            ram_we_q    <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                S_COLLECT: if (xfer) begin
                    if (in_last && idx != 2'd3) begin
                        state_q    <= S_ERR;
                        in_ready_q <= 1'b0;
                        error_q    <= 1'b1;
                    end else if (idx == 2'd3) begin
                        state_q    <= S_WRITE;
                        in_ready_q <= 1'b0;
                        ram_we_q   <= 1'b1;
                        last_q     <= in_last;
                    end
                end
                S_WRITE: begin
                    ram_we_q <= 1'b0;
                    ptr_q    <= ptr_q + ADDR_SIZE'(1);
                    cnt_q    <= cnt_q + (ADDR_SIZE+1)'(1);
                    if (last_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q     <= S_CSUM;
                        in_ready_q  <= 1'b1;
`else
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        cpu_reset_q <= 1'b0;
`endif
                    end else if (ptr_q == ADDR_SIZE'(RAM_SIZE - 1)) begin
                        state_q <= S_ERR;
                        error_q <= 1'b1;
                    end else begin
                        state_q    <= S_COLLECT;
                        in_ready_q <= 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                // in_last is deliberately ignored while collecting the checksum word.
                S_CSUM: if (xfer && idx == 2'd3) begin
                    in_ready_q <= 1'b0;
                    if (csum_word == acc) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        cpu_reset_q <= 1'b0;
                    end else begin
                        state_q <= S_ERR;
                        error_q <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ptr_q;
    assign ram_wdata  = word;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_mcpu_loader.sv
// tb_mcpu_loader: random and directed images checked against a word-level model of the loader.
module tb_mcpu_loader;

    logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_last = 1'b0;
    logic [3:0]  in_nibble = 4'h0;
    logic        in_ready, ram_we, cpu_reset, done, error;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [8:0]  word_count;

    typedef struct {
        int          c;
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    int          total = 0, passed = 0, cyc = 0, nwrites = 0, vmode = 0;
    bit          active = 1'b0;
    wr_t         exp_q[$];
    logic [3:0]  s_nib[$];
    bit          s_last[$];
    logic [15:0] exp_w[$];
    logic [7:0]  cap_addr = 8'hxx;
    logic [15:0] cap_data = 16'hxxxx;

    mcpu_loader dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_nibble (in_nibble),
        .in_last   (in_last),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Every cycle: writes must appear exactly when and where the model scheduled them.
    always @(negedge clk) begin
        if (active && !reset) begin
            if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
                chk("ram_we", ram_we, 1);
                chk("ram_addr", ram_addr, exp_q[0].a);
                chk("ram_wdata", ram_wdata, exp_q[0].d);
                exp_q.delete(0);
            end else
                chk("ram_we_idle", ram_we, 0);
            if (ram_we) begin
                cap_addr = ram_addr;
                cap_data = ram_wdata;
                nwrites++;
            end
            chk("done_error_exclusive", done & error, 0);
            chk("cpu_reset_vs_done", cpu_reset, !done);
        end
    end

    // Word-level reference: walks the nibble stream four at a time.
    // st: 0 still loading, 1 done, 2 error.
    task automatic model(output int acc, output int nw, output int st);
        logic [15:0] w = 16'h0, x = 16'h0;
        bit csum = 1'b0;
        acc = 0; nw = 0; st = 0;
        exp_w.delete();
        for (int j = 0; j < s_nib.size(); j++) begin
            if (st != 0) break;
            acc++;
            w = {w[11:0], s_nib[j]};
            if (csum) begin
                if (j % 4 == 3) st = (w == x) ? 1 : 2;
            end else if (s_last[j] && j % 4 != 3)
                st = 2;
            else if (j % 4 == 3) begin
                exp_w.push_back(w);
                x ^= w;
                nw++;
                if (s_last[j]) begin
`ifdef LOADER_CHECKSUM_EN
                    csum = 1'b1;
`else
                    st = 1;
`endif
                end else if (nw == 256)
                    st = 2;
            end
        end
    endtask

    task automatic push_word(input logic [15:0] w, input bit last);
        for (int i = 0; i < 4; i++) begin
            s_nib.push_back(w[15-4*i -: 4]);
            s_last.push_back(last && i == 3);
        end
    endtask

    task automatic finish_image(input logic [15:0] x, input bit good);
`ifdef LOADER_CHECKSUM_EN
        push_word(good ? x : x ^ 16'h0001, 1'b0);
`else
        if (!good && x == 16'h0) $display("note: checksum unused in this build");
`endif
    endtask

    task automatic feed(output int acc);
        int  j = 0, stall = 0;
        wr_t e;
        acc = 0;
        while (j < s_nib.size() && stall < 30) begin
            @(negedge clk);
            in_valid  = vmode == 1 ? 1'b1 : vmode == 2 ? 1'(cyc % 2) : 1'($urandom_range(0, 2) != 0);
            in_nibble = in_valid ? s_nib[j] : 4'($urandom);
            in_last   = in_valid ? s_last[j] : 1'($urandom);
            if (in_valid && in_ready) begin
                if (j % 4 == 3 && j / 4 < exp_w.size()) begin
                    e.c = cyc + 1;
                    e.a = 8'(j / 4);
                    e.d = exp_w[j / 4];
                    exp_q.push_back(e);
                end
                j++;
                acc++;
                stall = 0;
            end else
                stall++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_image(input string tag);
        int acc, eacc, enw, est;
        model(eacc, enw, est);
        feed(acc);
        if (est != 0) begin
            repeat (6) begin
                @(negedge clk);
                in_valid  = 1'b1;
                in_nibble = 4'($urandom);
                in_last   = 1'($urandom);
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_accepted"}, acc, eacc);
        chk({tag, "_word_count"}, word_count, enw);
        chk({tag, "_done"}, done, est == 1);
        chk({tag, "_error"}, error, est == 2);
        chk({tag, "_in_ready"}, in_ready, est == 0);
        chk({tag, "_pending_writes"}, exp_q.size(), 0);
        s_nib.delete();
        s_last.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_word_count", word_count, 0);
        chk("rst_flags", {done, error, cpu_reset, ram_we}, 4'b0010);
    endtask

    initial begin
        int          w0, n, mode, j;
        logic [15:0] w, x;
        repeat (2) @(negedge clk);
        active = 1'b1;
        do_reset();

        vmode = 1;
        s_nib = '{4'hE, 4'hE, 4'h2, 4'hC};
        s_last = '{0, 0, 0, 1};
        finish_image(16'hEE2C, 1'b1);
        w0 = nwrites;
        run_image("one_word");
        chk("one_word_addr", cap_addr, 8'h00);
        chk("one_word_data", cap_data, 16'hEE2C);
        chk("one_word_done", done, 1);
        chk("one_word_count", word_count, 1);
        chk("one_word_writes", nwrites - w0, 1);

        do_reset();
        vmode = 2;
        push_word(16'h1E2C, 1'b0);
        push_word(16'h2F27, 1'b0);
        push_word(16'h3E04, 1'b1);
        finish_image(16'h1E2C ^ 16'h2F27 ^ 16'h3E04, 1'b1);
        w0 = nwrites;
        run_image("three_words");
        chk("three_words_last_addr", cap_addr, 8'h02);
        chk("three_words_last_data", cap_data, 16'h3E04);
        chk("three_words_count", word_count, 3);
        chk("three_words_writes", nwrites - w0, 3);

        do_reset();
        vmode = 0;
        s_nib = '{4'h1, 4'h2};
        s_last = '{0, 1};
        w0 = nwrites;
        run_image("partial_last");
        chk("partial_last_error", error, 1);
        chk("partial_last_cpu_reset", cpu_reset, 1);
        chk("partial_last_writes", nwrites - w0, 0);

        do_reset();
        vmode = 1;
        for (int k = 0; k < 256; k++) push_word(16'($urandom), 1'b0);
        s_nib.push_back(4'h5);
        s_last.push_back(1'b0);
        w0 = nwrites;
        run_image("overflow");
        chk("overflow_writes", nwrites - w0, 256);
        chk("overflow_error", error, 1);
        chk("overflow_in_ready", in_ready, 0);
        chk("overflow_count", word_count, 256);

        do_reset();
        vmode = 0;
        s_nib = '{4'h7, 4'h3};
        s_last = '{0, 0};
        run_image("mid_word");
        do_reset();
        push_word(16'hA5C3, 1'b1);
        finish_image(16'hA5C3, 1'b1);
        run_image("after_abort");
        chk("after_abort_addr", cap_addr, 8'h00);
        chk("after_abort_data", cap_data, 16'hA5C3);

`ifdef LOADER_CHECKSUM_EN
        for (int g = 0; g < 2; g++) begin
            do_reset();
            vmode = 1;
            push_word(16'h1234, 1'b0);
            push_word(16'h00FF, 1'b1);
            push_word(g == 0 ? 16'h12CB : 16'h12CA, 1'b0);
            w0 = nwrites;
            run_image("checksum");
            chk("checksum_done", done, g == 0);
            chk("checksum_error", error, g == 1);
            chk("checksum_writes", nwrites - w0, 2);
        end
`endif

        for (int r = 0; r < 25; r++) begin
            do_reset();
            vmode = $urandom_range(0, 2);
            n = $urandom_range(1, 6);
            mode = $urandom_range(0, 4);
            x = 16'h0;
            for (int k = 0; k < n; k++) begin
                w = 16'($urandom);
                x ^= w;
                push_word(w, k == n - 1 && mode != 4);
            end
            if (mode == 3) begin
                j = 4 * $urandom_range(0, n - 1) + $urandom_range(0, 2);
                s_last[j] = 1'b1;
            end
            if (mode < 3) finish_image(x, $urandom_range(0, 3) != 0);
            run_image("random");
        end

        active = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mcpu_loader.md
MCPU_LOADER -- requirements
Module: mcpu_loader

Interface
REQ-001 Parameters SHALL be: WORD_SIZE, default 16, RAM word width; OPCODE_SIZE, default 4, nibble/field width; RAM_SIZE, default 256, words loadable; ADDR_SIZE, default 8, RAM address width.
REQ-002 Ports SHALL be: clk  input  1  single clock, all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  in_nibble valid this cycle.
REQ-005 in_ready  output  1  loader accepts a nibble this cycle; transfer = in_valid & in_ready.
REQ-006 in_nibble  input  OPCODE_SIZE  image field, most-significant field of each word first (opcode, operand, operand, operand).
REQ-007 in_last  input  1  qualifies the final nibble of the final program word.
REQ-008 ram_we  output  1  one-cycle RAM write strobe.
REQ-009 ram_addr  output  ADDR_SIZE  RAM write address.
REQ-010 ram_wdata  output  WORD_SIZE  assembled instruction word.
REQ-011 cpu_reset  output  1  holds MCPU in reset while loading or on error.
REQ-012 done  output  1  image loaded successfully (sticky).
REQ-013 error  output  1  malformed image (sticky).
REQ-014 word_count  output  ADDR_SIZE+1  words written to RAM so far.

Function
REQ-015 FSM states SHALL be S_COLLECT, S_WRITE, S_DONE, S_ERR (plus S_CSUM when configured).
REQ-016 S_COLLECT: in_ready=1; each transfer shifts in_nibble into a WORD_SIZE shift register from the LSB side and increments a 2-bit nibble index.
REQ-017 The fourth transfer of a word SHALL move to S_WRITE and latch in_last into a last flag.
REQ-018 in_last on nibble index 0..2 SHALL move to S_ERR (partial word); that word is not written.
REQ-019 S_WRITE SHALL last exactly one cycle: in_ready=0, ram_we=1, ram_addr=write pointer, ram_wdata=assembled word; pointer and word_count increment.
REQ-020 From S_WRITE: last flag set -> S_DONE (or S_CSUM); else pointer wrapped past RAM_SIZE-1 -> S_ERR (overflow); else -> S_COLLECT with index 0.
REQ-021 Latency: ram_we SHALL assert the cycle after the fourth accepted nibble; throughput one word per 5 cycles at best.
REQ-022 S_DONE: cpu_reset=0, done=1, in_ready=0, ram_we=0; terminal until reset; inputs ignored.
REQ-023 S_ERR: cpu_reset=1, error=1, in_ready=0, ram_we=0; terminal until reset.
REQ-024 cpu_reset SHALL be 1 in every state except S_DONE; done and error SHALL never be 1 together.
REQ-025 in_valid low SHALL stall without state change; no nibble is lost or duplicated.

Reset
REQ-026 reset SHALL, on the clock edge, force S_COLLECT, pointer=0, nibble index=0, word_count=0, shift register=0, ram_we=0, done=0, error=0, cpu_reset=1, in_ready=1 in the following cycle.
REQ-027 reset mid-word or mid-write SHALL abort; already-written RAM words are not cleared; the next image restarts at address 0.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN defined: after the last data word, S_CSUM SHALL accept four more nibbles forming a checksum word, never written to RAM; equal to XOR of all written words -> S_DONE, else -> S_ERR; in_last ignored in S_CSUM.
REQ-029 LOADER_CHECKSUM_EN undefined: S_CSUM and the XOR accumulator SHALL not exist; last word goes directly to S_DONE.

Structure
REQ-030 A shared package SHALL hold the FSM state enum typedef, WORD_SIZE, OPCODE_SIZE, ADDR_SIZE, RAM_SIZE constants, shared with MCPU.
REQ-031 One sub-module, mcpu_loader_asm (nibble shift register, index counter, XOR accumulator), SHALL be used; the FSM stays in mcpu_loader.

Verification
REQ-032 Nibbles E,E,2,C with in_last on C -> ram_we one cycle later, addr 0x00, wdata 0xEE2C; next cycle done=1, cpu_reset=0, word_count=1.
REQ-033 Three words 0x1E2C,0x2F27,0x3E04, in_valid toggled every other cycle -> writes to 0x00..0x02 in order, word_count=3, done=1.
REQ-034 in_last on second nibble of first word -> error=1, cpu_reset=1, no ram_we ever.
REQ-035 256 words without in_last, then one more nibble -> 256 writes, then error=1, in_ready=0.
REQ-036 With LOADER_CHECKSUM_EN: words 0x1234,0x00FF then checksum 0x12CB -> done=1; checksum 0x12CA -> error=1; only 2 RAM writes either way.
REQ-037 reset asserted after two nibbles of word 1 -> in_ready=1, word_count=0; a fresh one-word image writes address 0x00.
